// File: rtl/npu_dot_pkg.sv
// npu_dot_pkg: shared state type and fixed-point helpers for the NPU dot-product engine.
package npu_dot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    OUTPUT
  } state_t;

  // Working widths for the finalise helper; wide enough for any sensible accumulator.
  localparam int RS_WIDTH  = 128;
  localparam int RES_WIDTH = 64;

  typedef struct packed {
    logic                 sat;
    logic [RES_WIDTH-1:0] value;
  } round_sat_t;

  // Accumulator width that can never overflow: full products, lane growth, beat growth.
  function automatic int acc_width(input int data_width, input int lanes, input int beats_width);
    return 2 * data_width + $clog2(lanes) + beats_width;
  endfunction

  // Round half up, drop the extra fractional bits, then clip to the signed result range.
  function automatic round_sat_t round_sat(input logic signed [RS_WIDTH-1:0] acc,
                                           input int frac_bits,
                                           input int data_width);
    logic signed [RS_WIDTH-1:0] one;
    logic signed [RS_WIDTH-1:0] rounded;
    logic signed [RS_WIDTH-1:0] shifted;
    logic signed [RS_WIDTH-1:0] max_v;
    logic signed [RS_WIDTH-1:0] min_v;
    round_sat_t r;
    one     = {{(RS_WIDTH-1){1'b0}}, 1'b1};
    rounded = acc;
    if (frac_bits > 0) begin
      rounded = acc + (one <<< (frac_bits - 1));
    end
    shifted = rounded >>> frac_bits;
    max_v   = (one <<< (data_width - 1)) - one;
    min_v   = -(one <<< (data_width - 1));
    r.sat   = 1'b0;
    r.value = shifted[RES_WIDTH-1:0];
    if (shifted > max_v) begin
      r.sat   = 1'b1;
      r.value = max_v[RES_WIDTH-1:0];
    end else if (shifted < min_v) begin
      r.sat   = 1'b1;
      r.value = min_v[RES_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/npu_dot_accumulator_if.sv
// npu_dot_accumulator_if: configuration, beat input stream and result output stream of the
// dot-product engine. The master side drives beats and accepts results; the slave is the engine.
interface npu_dot_accumulator_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 16,
  parameter int BEATS_WIDTH = 8
);

  logic [BEATS_WIDTH-1:0]      cfg_beats;
  logic [DATA_WIDTH-1:0]       bias;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic [LANES*DATA_WIDTH-1:0] in_weight;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_result;
  logic                        out_saturated;
  logic                        busy;

  modport master (
    output cfg_beats, bias, in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_result, out_saturated, busy
  );

  modport slave (
    input  cfg_beats, bias, in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_result, out_saturated, busy
  );

endinterface

// File: rtl/npu_lane_adder_tree.sv
// npu_lane_adder_tree: pairwise signed sum of all lane products, registered as pipeline stage S2.
// LANES must be a power of two so every tree level halves cleanly.
module npu_lane_adder_tree #(
  parameter int LANES  = 16,
  parameter int PROD_W = 32,
  parameter int SUM_W  = PROD_W + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [LANES*PROD_W-1:0] products,
  output logic                    out_valid,
  output logic [SUM_W-1:0]        sum
);

  localparam int LEVELS = $clog2(LANES);

  logic signed [SUM_W-1:0]  node [LANES];
  logic signed [PROD_W-1:0] lane_p;

  // Sign-extend every product, then fold neighbours in place one tree level at a time.
  always_comb begin
    node   = '{default: '0};
    lane_p = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_p  = products[i*PROD_W +: PROD_W];
      node[i] = {{(SUM_W-PROD_W){lane_p[PROD_W-1]}}, lane_p};
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < (LANES >> (lvl + 1)); i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
  end

  // Register the root of the tree together with its valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= node[0];
      end
    end
  end

endmodule

// File: rtl/npu_dot_accumulator.sv
// npu_dot_accumulator: fixed-point dot-product engine for the NPU neuron datapath.
// Pipeline: S1 lane products, S2 lane-sum tree, S3 accumulate; one rounded, saturated
// result per vector of cfg_beats beats plus bias.
// Optional feature: define NPU_DOT_RELU_EN to force negative results to zero after saturation.
module npu_dot_accumulator
  import npu_dot_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LANES       = 16,
  parameter int BEATS_WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  npu_dot_accumulator_if.slave bus
);

  localparam int PROD_W    = 2 * DATA_WIDTH;
  localparam int SUM_W     = PROD_W + $clog2(LANES);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, LANES, BEATS_WIDTH);

  state_t                   state;
  logic [BEATS_WIDTH-1:0]   beat_cnt;
  logic [BEATS_WIDTH-1:0]   beats_q;
  logic [BEATS_WIDTH-1:0]   beats_eff;
  logic                     accept;
  logic [LANES*PROD_W-1:0]  prod_c;
  logic [LANES*PROD_W-1:0]  prod_q;
  logic                     s1_valid;
  logic                     s2_valid;
  logic [SUM_W-1:0]         sum_q;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic signed [RS_WIDTH-1:0]  acc_wide;
  round_sat_t               rs;
  logic [DATA_WIDTH-1:0]    result_c;
  logic                     sat_c;
  logic                     out_valid_q;
  logic [DATA_WIDTH-1:0]    out_result_q;
  logic                     out_sat_q;
  logic                     unused_rs_bits;

  assign bus.in_ready      = !reset && ((state == IDLE) || (state == ACCUM));
  assign bus.busy          = (state != IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_saturated = out_sat_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign beats_eff = (bus.cfg_beats == '0) ? BEATS_WIDTH'(1) : bus.cfg_beats;
  assign bias_ext  = {{(ACC_WIDTH-DATA_WIDTH){bus.bias[DATA_WIDTH-1]}}, bus.bias};
  assign sum_ext   = {{(ACC_WIDTH-SUM_W){sum_q[SUM_W-1]}}, sum_q};
  assign acc_wide  = {{(RS_WIDTH-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};

  // Full-width signed product for each lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] d_l;
    logic signed [DATA_WIDTH-1:0] w_l;
    logic signed [PROD_W-1:0]     p_l;
    assign d_l = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_l = bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH];
    assign p_l = d_l * w_l;
    assign prod_c[i*PROD_W +: PROD_W] = p_l;
  end

  // S1: capture the lane products of every accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      prod_q   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        prod_q <= prod_c;
      end
    end
  end

  npu_lane_adder_tree #(
    .LANES  (LANES),
    .PROD_W (PROD_W),
    .SUM_W  (SUM_W)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .products  (prod_q),
    .out_valid (s2_valid),
    .sum       (sum_q)
  );

  // S3: seed with the scaled bias on the first beat, then add each lane sum as it arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (accept && (state == IDLE)) begin
      acc <= bias_ext <<< FRAC_BITS;
    end else if (s2_valid) begin
      acc <= acc + sum_ext;
    end
  end

  // Finalise the accumulator into the output format; the optional ReLU follows saturation.
  always_comb begin
    rs       = round_sat(acc_wide, FRAC_BITS, DATA_WIDTH);
    result_c = rs.value[DATA_WIDTH-1:0];
    sat_c    = rs.sat;
`ifdef NPU_DOT_RELU_EN
    if (result_c[DATA_WIDTH-1]) begin
      result_c = '0;
    end
`else
    result_c = rs.value[DATA_WIDTH-1:0];
`endif
  end

  // Upper result bits are only sign copies of the clipped value.
  assign unused_rs_bits = ^rs.value[RES_WIDTH-1:DATA_WIDTH];

  // Vector sequencing: count beats, drain the pipeline, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      beats_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            beats_q <= beats_eff;
            if (beats_eff == BEATS_WIDTH'(1)) begin
              beat_cnt <= '0;
              state    <= FLUSH;
            end else begin
              beat_cnt <= BEATS_WIDTH'(1);
              state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (beat_cnt == (beats_q - BEATS_WIDTH'(1))) begin
              beat_cnt <= '0;
              state    <= FLUSH;
            end else begin
              beat_cnt <= beat_cnt + BEATS_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (!s1_valid && !s2_valid) begin
            out_valid_q  <= 1'b1;
            out_result_q <= result_c;
            out_sat_q    <= sat_c;
            state        <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_dot_accumulator.sv
// tb_npu_dot_accumulator: directed and randomised vectors checked against an arithmetic
// dot-product model (Q8.8, 16 lanes).
module tb_npu_dot_accumulator;

  localparam int DW    = 16;
  localparam int FB    = 8;
  localparam int LANES = 16;
  localparam int BW    = 8;
  localparam int LW    = DW * LANES;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;

  logic [LW-1:0] vec_data[$];
  logic [LW-1:0] vec_weight[$];

  npu_dot_accumulator_if #(.DATA_WIDTH(DW), .LANES(LANES), .BEATS_WIDTH(BW)) bus ();

  npu_dot_accumulator #(
    .DATA_WIDTH  (DW),
    .FRAC_BITS   (FB),
    .LANES       (LANES),
    .BEATS_WIDTH (BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic longint sext(input logic [DW-1:0] v);
    longint r;
    r = longint'(v);
    if (v[DW-1]) r = r - (longint'(1) << DW);
    return r;
  endfunction

  function automatic logic [LW-1:0] splat(input logic [DW-1:0] v);
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_lanes(input bit full);
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      if (full) r[i*DW +: DW] = DW'($urandom);
      else      r[i*DW +: DW] = DW'($urandom_range(255)) - DW'(128);
    end
    return r;
  endfunction

  task automatic load_const(input int n, input logic [LW-1:0] d, input logic [LW-1:0] w);
    vec_data.delete();
    vec_weight.delete();
    for (int k = 0; k < n; k++) begin
      vec_data.push_back(d);
      vec_weight.push_back(w);
    end
  endtask

  task automatic load_random(input int n, input bit full);
    vec_data.delete();
    vec_weight.delete();
    for (int k = 0; k < n; k++) begin
      vec_data.push_back(rand_lanes(full));
      vec_weight.push_back(rand_lanes(full));
    end
  endtask

  // Reference: exact integer dot product plus scaled bias, round half up, clip, optional ReLU.
  task automatic model_vector(input logic [DW-1:0] b, output logic [DW-1:0] exp_res, output logic exp_sat);
    longint total;
    longint q;
    total = sext(b) * (longint'(1) << FB);
    foreach (vec_data[k]) begin
      for (int i = 0; i < LANES; i++) begin
        total += sext(vec_data[k][i*DW +: DW]) * sext(vec_weight[k][i*DW +: DW]);
      end
    end
    q = (total + (longint'(1) << (FB - 1))) >>> FB;
    exp_sat = 1'b0;
    if (q > MAXV) begin
      q = MAXV;
      exp_sat = 1'b1;
    end else if (q < MINV) begin
      q = MINV;
      exp_sat = 1'b1;
    end
`ifdef NPU_DOT_RELU_EN
    if (q < 0) q = 0;
`endif
    exp_res = q[DW-1:0];
  endtask

  // Send the loaded beats, then check latency, result, hold behaviour and the handshake.
  task automatic run_vector(input string tag, input logic [BW-1:0] beats_cfg, input logic [DW-1:0] b,
                            input int max_gap, input int hold);
    logic [DW-1:0] exp_res;
    logic          exp_sat;
    int            cycles;
    int            gap;
    bit            stalled;
    model_vector(b, exp_res, exp_sat);
    stalled = 1'b0;
    foreach (vec_data[k]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      repeat (gap) tick();
      if (k == 0) begin
        bus.cfg_beats = beats_cfg;
        bus.bias      = b;
      end else begin
        bus.cfg_beats = BW'($urandom);
        bus.bias      = DW'($urandom);
      end
      bus.in_data   = vec_data[k];
      bus.in_weight = vec_weight[k];
      bus.in_valid  = 1'b1;
      cycles = 0;
      while (bus.in_ready !== 1'b1 && cycles < 50) begin
        stalled = 1'b1;
        tick();
        cycles++;
      end
      tick();
      bus.in_valid = 1'b0;
    end
    check_output({tag, " in_ready stall"}, 64'(stalled), 64'(0));
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_output({tag, " latency"}, 64'(cycles), 64'(3));
    check_output({tag, " result"}, 64'(bus.out_result), 64'(exp_res));
    check_output({tag, " saturated"}, 64'(bus.out_saturated), 64'(exp_sat));
    repeat (hold) begin
      tick();
      check_output({tag, " held valid"}, 64'(bus.out_valid), 64'(1));
      check_output({tag, " held result"}, 64'(bus.out_result), 64'(exp_res));
      check_output({tag, " held in_ready"}, 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_output({tag, " valid after handshake"}, 64'(bus.out_valid), 64'(0));
    check_output({tag, " in_ready after handshake"}, 64'(bus.in_ready), 64'(1));
    check_output({tag, " busy after handshake"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    bit seen;
    int nb;
    bit full;
    logic [DW-1:0] b;
    logic [LW-1:0] lane0;

    $display("[TB] starting npu_dot_accumulator bench");
    bus.cfg_beats = '0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b0;

    // Step: reset state
    reset = 1'b1;
    repeat (3) tick();
    check_output("reset out_valid", 64'(bus.out_valid), 64'(0));
    check_output("reset out_result", 64'(bus.out_result), 64'(0));
    check_output("reset out_saturated", 64'(bus.out_saturated), 64'(0));
    check_output("reset busy", 64'(bus.busy), 64'(0));
    check_output("reset in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    tick();
    check_output("idle in_ready", 64'(bus.in_ready), 64'(1));

    // Step: single beat of unit values
    load_const(1, splat(16'h0100), splat(16'h0100));
    run_vector("single beat", 8'd1, 16'h0000, 0, 0);

    // Step: 49 back-to-back beats with bias
    load_const(49, splat(16'h0080), splat(16'h0002));
    run_vector("49 beats", 8'd49, 16'h0100, 0, 0);

    // Step: positive and negative saturation
    load_const(1, splat(16'h7FFF), splat(16'h7FFF));
    run_vector("positive saturation", 8'd1, 16'h0000, 0, 0);
    load_const(1, splat(16'h8000), splat(16'h7FFF));
    run_vector("negative saturation", 8'd1, 16'h0000, 0, 0);

    // Step: half rounds up, cfg_beats of zero means one beat
    lane0 = '0;
    lane0[DW-1:0] = 16'h0001;
    vec_data.delete();
    vec_weight.delete();
    vec_data.push_back(lane0);
    lane0[DW-1:0] = 16'h0080;
    vec_weight.push_back(lane0);
    run_vector("rounding", 8'd0, 16'h0000, 0, 0);

    // Step: backpressure holds the result for ten cycles
    load_const(1, splat(16'h0100), splat(16'h0100));
    run_vector("backpressure", 8'd1, 16'h0000, 0, 10);

    // Step: reset in the middle of a four-beat vector discards it
    bus.cfg_beats = 8'd4;
    bus.bias      = '0;
    bus.in_data   = splat(16'h0100);
    bus.in_weight = splat(16'h0100);
    bus.in_valid  = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_output("mid-vector reset in_ready", 64'(bus.in_ready), 64'(0));
    check_output("mid-vector reset busy", 64'(bus.busy), 64'(0));
    tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check_output("discarded vector no out_valid", 64'(seen), 64'(0));
    load_const(1, splat(16'h0100), splat(16'h0100));
    run_vector("after reset", 8'd1, 16'h0000, 0, 0);

    // Step: randomised vectors with gaps, mid-vector config noise and random backpressure
    for (int v = 0; v < 20; v++) begin
      nb   = int'($urandom_range(6));
      full = ($urandom_range(3) == 0);
      if (full) b = DW'($urandom);
      else      b = DW'($urandom_range(4095)) - DW'(2048);
      load_random((nb == 0) ? 1 : nb, full);
      run_vector($sformatf("random %0d", v), BW'(nb), b, 2, int'($urandom_range(2)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
